// File: rtl/bs_pkg.sv
// Shared fixed-point types, constants and FSM states for the call lower-bound engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bs_pkg;

   // Signed Q6.10: 6 integer bits (including sign), 10 fraction bits.
   localparam int FRAC_BITS = 10;

   typedef logic signed [15:0] q610_t;

   localparam q610_t Q_ONE  = 16'sd1024;   // 1.0
   localparam q610_t Q_INV6 = 16'sd171;    // ~1/6, cubic Taylor coefficient
   localparam q610_t Q_MAX  = 16'sh7FFF;   // largest representable value
   localparam q610_t Q_MIN  = 16'sh8000;   // most negative representable value

   // One state per pipeline step of the sequential evaluation.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RT   = 3'd1,
      X2   = 3'd2,
      X3   = 3'd3,
      EXP  = 3'd4,
      DISC = 3'd5,
      SUB  = 3'd6,
      DONE = 3'd7
   } state_t;

   // Clamp a wide signed intermediate to the Q6.10 range.
   function automatic q610_t sat16(input logic signed [31:0] v);
      if (v > 32'sd32767) begin
         return Q_MAX;
      end else if (v < -32'sd32768) begin
         return Q_MIN;
      end else begin
         return v[15:0];
      end
   endfunction

endpackage

// File: rtl/q610_mul.sv
// Combinational Q6.10 multiply: signed 16x16 product, arithmetic shift by FRAC_BITS, saturate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module q610_mul
   import bs_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] p
);

   logic signed [31:0] prod;
   logic signed [31:0] scaled;

   // Full-precision product, rescaled to Q6.10 and clamped to 16 bits.
   always_comb begin
      prod   = $signed(a) * $signed(b);
      scaled = prod >>> FRAC_BITS;
      p      = sat16(scaled);
   end

endmodule

// File: rtl/bs_call_bound.sv
// Computes the call lower bound max(S - K*exp(-r*T), 0) in Q6.10 with a cubic exp approximation.
// Latency: done rises on the 7th rising edge counting the edge that accepts start.
// Backpressure: start is ignored while busy; no queueing, result held until the next accepted start.
module bs_call_bound
   import bs_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] S,
   input  logic [15:0] K,
   input  logic [15:0] r,
   input  logic [15:0] sigma,
   input  logic [15:0] T,
   output logic        done,
   output logic        busy,
   output logic [15:0] call_bound,
   output logic        range_err
);

   state_t state_q, state_d;

   // Job operands captured at the accepting edge.
   q610_t s_q, s_d;
   q610_t k_q, k_d;
   q610_t r_q, r_d;
   q610_t t_q, t_d;

   // Intermediates produced one per state.
   q610_t x_q, x_d;
   q610_t x2_q, x2_d;
   q610_t x3_q, x3_d;
   q610_t e_q, e_d;
   q610_t kd_q, kd_d;

   // Published result, only updated when entering DONE.
   q610_t bound_q, bound_d;
   logic  rerr_q, rerr_d;

   // Shared multiplier operands.
   q610_t mul_a, mul_b, mul_p;

   logic               accept;
   logic signed [31:0] e_sum;
   logic signed [16:0] diff;

   // Volatility is irrelevant to the lower bound; the port only keeps the
   // interface identical to the full pricing core.
   logic unused_sigma;
   assign unused_sigma = ^sigma;

   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   q610_mul u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   // Next-state logic: fixed one-state-per-cycle walk, start only honoured when not busy.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RT;
         RT:      state_d = X2;
         X2:      state_d = X3;
         X3:      state_d = EXP;
         EXP:     state_d = DISC;
         DISC:    state_d = SUB;
         SUB:     state_d = DONE;
         DONE:    if (start) state_d = RT;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: steer the shared multiplier and compute the register updates for the current step.
   always_comb begin
      s_d     = s_q;
      k_d     = k_q;
      r_d     = r_q;
      t_d     = t_q;
      x_d     = x_q;
      x2_d    = x2_q;
      x3_d    = x3_q;
      e_d     = e_q;
      kd_d    = kd_q;
      bound_d = bound_q;
      rerr_d  = rerr_q;
      mul_a   = '0;
      mul_b   = '0;
      e_sum   = '0;
      diff    = '0;

      if (accept) begin
         s_d = S;
         k_d = K;
         r_d = r;
         t_d = T;
      end

      unique case (state_q)
         RT: begin
            mul_a = r_q;
            mul_b = t_q;
            x_d   = mul_p;
         end
         X2: begin
            mul_a = x_q;
            mul_b = x_q;
            x2_d  = mul_p;
         end
         X3: begin
            mul_a = x2_q;
            mul_b = x_q;
            x3_d  = mul_p;
         end
         EXP: begin
            // exp(-x) ~ 1 - x + x^2/2 - x^3/6
            mul_a = x3_q;
            mul_b = Q_INV6;
            e_sum = 32'(Q_ONE) - 32'(x_q) + 32'(x2_q >>> 1) - 32'(mul_p);
            e_d   = sat16(e_sum);
         end
         DISC: begin
            mul_a = k_q;
            mul_b = e_q;
            kd_d  = mul_p;
         end
         SUB: begin
            // 17 bits holds any difference of two Q6.10 values without wrap.
            diff = 17'(s_q) - 17'(kd_q);
            if ((s_q < 0) || (k_q < 0) || (diff < 0)) begin
               bound_d = '0;
            end else if (diff > 17'sd32767) begin
               bound_d = Q_MAX;
            end else begin
               bound_d = diff[15:0];
            end
            // Out-of-range x is flagged but its computed result is still published.
            rerr_d = (s_q < 0) || (k_q < 0) || (x_q < 0) || (x_q > Q_ONE);
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset aborts any job and clears everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         k_q     <= '0;
         r_q     <= '0;
         t_q     <= '0;
         x_q     <= '0;
         x2_q    <= '0;
         x3_q    <= '0;
         e_q     <= '0;
         kd_q    <= '0;
         bound_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         k_q     <= k_d;
         r_q     <= r_d;
         t_q     <= t_d;
         x_q     <= x_d;
         x2_q    <= x2_d;
         x3_q    <= x3_d;
         e_q     <= e_d;
         kd_q    <= kd_d;
         bound_q <= bound_d;
         rerr_q  <= rerr_d;
      end
   end

   assign done       = (state_q == DONE);
   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign call_bound = bound_q;
   assign range_err  = rerr_q;

endmodule

// File: tb/tb_bs_call_bound.sv
// Directed self-checking bench for bs_call_bound with hand-computed Q6.10 results.
// Latency: checks done on the 7th edge after an accepted start.
// Backpressure: exercises ignored starts during busy and back-to-back starts from DONE.
module tb_bs_call_bound;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] s_i, k_i, r_i, sig_i, t_i;
   logic        done, busy, range_err;
   logic [15:0] call_bound;

   int checks = 0;
   int errors = 0;
   int lat, lowc;

   bs_call_bound dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .S          (s_i),
      .K          (k_i),
      .r          (r_i),
      .sigma      (sig_i),
      .T          (t_i),
      .done       (done),
      .busy       (busy),
      .call_bound (call_bound),
      .range_err  (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // mode 0: plain job; 1: extra start pulse after edge 3; 2: inputs scrambled after edge 2
   task automatic run_job(input logic [15:0] s, input logic [15:0] k, input logic [15:0] rr,
                          input logic [15:0] t, input int mode, output int lat_o, output int lowc_o);
      int e;
      e      = 0;
      lowc_o = 0;
      @(negedge clk);
      s_i   = s;
      k_i   = k;
      r_i   = rr;
      t_i   = t;
      sig_i = 16'h0133;
      start = 1'b1;
      @(posedge clk);
      e = 1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", busy, 1);
      while (!done && e < 20) begin
         lowc_o++;
         if (mode == 1 && e == 3) start = 1'b1;
         if (mode == 2 && e == 2) begin
            s_i   = 16'h7FFF;
            k_i   = 16'h0000;
            r_i   = 16'h0000;
            t_i   = 16'h0000;
            sig_i = 16'hFFFF;
         end
         @(posedge clk);
         e++;
         @(negedge clk);
         start = 1'b0;
      end
      lat_o = e;
      chk("busy_at_done", busy, 0);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      s_i   = '0;
      k_i   = '0;
      r_i   = '0;
      sig_i = '0;
      t_i   = '0;
      repeat (2) @(negedge clk);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bound", call_bound, 16'h0000);
      chk("rst_rerr", range_err, 0);
      rst = 1'b1;

      // S=25, K=25, r=0.05, T=1: x=51, x2=2, x3=0, e=974, kd=24350
      run_job(16'd25600, 16'd25600, 16'd51, 16'd1024, 0, lat, lowc);
      chk("c1_lat", lat, 7);
      chk("c1_bound", call_bound, 16'h04E2);
      chk("c1_rerr", range_err, 0);

      @(negedge clk);
      chk("c1_hold_done", done, 1);
      chk("c1_hold_bound", call_bound, 16'h04E2);

      // Back-to-back from DONE. S=30, r=0.03: e=994, kd=24850
      run_job(16'd30720, 16'd25600, 16'd30, 16'd1024, 0, lat, lowc);
      chk("c2_lat", lat, 7);
      chk("c2_low_cycles", lowc, 6);
      chk("c2_bound", call_bound, 16'h16EE);
      chk("c2_rerr", range_err, 0);

      // K=30: kd=29220 > S, clamp to zero
      run_job(16'd25600, 16'd30720, 16'd51, 16'd1024, 0, lat, lowc);
      chk("c3_bound", call_bound, 16'h0000);
      chk("c3_rerr", range_err, 0);

      run_job(16'd25600, 16'd25600, 16'd51, 16'd1024, 1, lat, lowc);
      chk("restart_lat", lat, 7);
      chk("restart_bound", call_bound, 16'h04E2);

      run_job(16'd25600, 16'd25600, 16'd51, 16'd1024, 2, lat, lowc);
      chk("latch_bound", call_bound, 16'h04E2);

      // Reset after edge 4 of a job
      @(negedge clk);
      s_i   = 16'd25600;
      k_i   = 16'd25600;
      r_i   = 16'd51;
      t_i   = 16'd1024;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b0;
      #1;
      chk("midrst_done", done, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_bound", call_bound, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      run_job(16'd30720, 16'd25600, 16'd30, 16'd1024, 0, lat, lowc);
      chk("postrst_lat", lat, 7);
      chk("postrst_bound", call_bound, 16'h16EE);

      // S=31.999, K=0
      run_job(16'h7FFF, 16'h0000, 16'd51, 16'd1024, 0, lat, lowc);
      chk("kzero_bound", call_bound, 16'h7FFF);
      chk("kzero_rerr", range_err, 0);

      // K=-1.0
      run_job(16'd25600, 16'hFC00, 16'd51, 16'd1024, 0, lat, lowc);
      chk("kneg_bound", call_bound, 16'h0000);
      chk("kneg_rerr", range_err, 1);

      // r=2.0, T=1: x=2048, x2=4096, x3=8192, x3/6=1368, e=-344, kd=-344 (K=1), S=1 -> 1368
      run_job(16'd1024, 16'd1024, 16'd2048, 16'd1024, 0, lat, lowc);
      chk("xrange_bound", call_bound, 16'h0558);
      chk("xrange_rerr", range_err, 1);

      // Same x but S=31.999: 32767+344 saturates
      run_job(16'h7FFF, 16'd1024, 16'd2048, 16'd1024, 0, lat, lowc);
      chk("sat_bound", call_bound, 16'h7FFF);
      chk("sat_rerr", range_err, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
